gray_codec_unit: RTL
====================

Name: gray_codec_unit

Overview:
Parametrised, handshaked Gray-code engine that replaces the combinational 16-bit crypto unit in the CPU's special-function path. It supports binary-to-Gray encode, iterative Gray-to-binary decode (STEP bits per cycle, MSB first) and XOR-parity reduce. Operands enter on a valid/ready port. Results are zero-extended to OUT_W and held on a valid/ready output port until consumed.

Parameters:
WIDTH, 16, operand width in bits (>=2)
STEP, 4, Gray-decode bits resolved per cycle (1..WIDTH)
OUT_W, 32, result width (>=WIDTH); upper bits zero

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand/opcode valid
in_ready  out  1  unit can accept (high only in IDLE)
a  in  WIDTH  operand
opcode  in  3  000 encode, 001 decode, 010 parity, others illegal
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
outcu  out  OUT_W  result, zero-extended
op_err  out  1  result came from illegal opcode; qualified by out_valid

Behaviour:
- Clocking and reset
  - Single clock domain. rst_n is asynchronous assert, synchronous deassert; the deassertion synchroniser is external.
  - Reset state: IDLE. in_ready=1, out_valid=0, outcu=0, op_err=0, chunk counter=0, carry=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE
  - in_ready=1. An accept is in_valid&&in_ready on a clock edge.
  - On accept with opcode 000: outcu <= zext(a ^ (a>>1)), op_err<=0, go to DONE.
  - On accept with opcode 010: outcu <= zext(^a) in bit 0, other bits 0, op_err<=0, go to DONE.
  - On accept with illegal opcode: outcu<=0, op_err<=1, go to DONE.
  - On accept with opcode 001: latch a into the operand register, clear the result, carry<=0, counter<=0, go to BUSY.
- BUSY (decode only)
  - in_ready=0.
  - Each cycle resolves one chunk, MSB first: b[i] = carry ^ g[i] for the chunk's top bit, then b[i] = b[i+1] ^ g[i] down the chunk.
  - carry <= the chunk's lowest resolved bit.
  - NCH = ceil(WIDTH/STEP) chunks. The final chunk holds WIDTH-(NCH-1)*STEP bits, which is fewer than STEP when WIDTH%STEP != 0. Lanes below bit 0 are masked and never written.
  - After chunk NCH-1, go to DONE.
  - Counter width is clog2(NCH)+1. No wrap occurs within an operation.
- DONE
  - out_valid=1, in_ready=0.
  - outcu and op_err are stable until the handshake out_valid&&out_ready, then go to IDLE.
  - No new operand is accepted in the handshake cycle. Peak throughput is one result per 2 cycles for encode, parity and illegal opcodes.
- Latency, from the accept edge to the first cycle with out_valid high:
  - 1 cycle for encode, parity and illegal opcodes.
  - 1+NCH cycles for decode.
- Handshake rules
  - in_valid is ignored outside IDLE; a and opcode are sampled only at accept.
  - out_ready is ignored outside DONE.
  - Backpressure of any length holds outcu bit-exact.
- Boundary conditions
  - STEP >= WIDTH: decode completes in one BUSY cycle (NCH=1).
  - STEP = 1: NCH = WIDTH.
  - rst_n low mid-BUSY or in DONE aborts immediately to the reset state; the partial result is discarded.
- Width rule: outcu[OUT_W-1:WIDTH] is always 0.

Decomposition:
- Package gray_codec_pkg:
  - opcode localparams OP_ENC=3'b000, OP_DEC=3'b001, OP_PAR=3'b010
  - state typedef {IDLE, BUSY, DONE}
  - a clog2-based function computing NCH
- Sub-module gray_dec_slice #(STEP): combinational chunk decoder.
  - Inputs: carry_in, g_chunk[STEP], lane mask.
  - Outputs: b_chunk[STEP], carry_out.
  - Instantiated once and time-multiplexed by the BUSY counter.

Test Plan:
1. WIDTH=16, STEP=4; encode a=16'h00FF -> out_valid 1 cycle after accept, outcu=32'h00000080, op_err=0.
2. Decode a=16'h0080 -> out_valid 5 cycles after accept, outcu=32'h000000FF. Decode a=16'h8000 -> outcu=32'h0000FFFF. in_ready low throughout.
3. Parity a=16'h0007 -> outcu=32'h00000001. Illegal opcode 3'b101 with a=16'hABCD -> outcu=0, op_err=1.
4. Backpressure: decode 16'h0080 with out_ready held low 6 cycles -> outcu stays 32'h000000FF and in_ready stays 0. Raise out_ready -> next cycle IDLE, in_ready=1. in_valid pulses during BUSY are ignored.
5. WIDTH=13, STEP=4 (partial chunk): decode a=13'h1000 -> outcu=32'h00001FFF after 1+4 cycles. Separate build with STEP=13 -> latency 2.
6. Assert rst_n low in the 2nd BUSY cycle of a decode -> asynchronously out_valid=0, outcu=0, in_ready=1. A following encode of 16'h0001 -> outcu=32'h00000001 with no residue.

Source files
------------

// File: rtl/gray_codec_pkg.sv
// Shared opcodes, FSM state type and chunk-count helpers for the Gray-code engine.
package gray_codec_pkg;

  localparam logic [2:0] OP_ENC = 3'b000;
  localparam logic [2:0] OP_DEC = 3'b001;
  localparam logic [2:0] OP_PAR = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_nch(input int width, input int step);
    return (width + step - 1) / step;
  endfunction

  // One spare bit so the counter never wraps within an operation.
  function automatic int calc_cnt_w(input int width, input int step);
    return $clog2(calc_nch(width, step)) + 1;
  endfunction

endpackage

// File: rtl/gray_dec_slice.sv
// Combinational Gray-to-binary chunk decoder; lane 0 is the chunk's most significant bit.
module gray_dec_slice #(
  parameter int STEP = 4
) (
  input  logic            i_carry,
  input  logic [STEP-1:0] i_g_chunk,
  input  logic [STEP-1:0] i_mask,
  output logic [STEP-1:0] o_b_chunk,
  output logic            o_carry
);

  logic w_acc;

  // Masked lanes pass the running bit through untouched, so o_carry is the lowest valid bit.
  always_comb begin
    o_b_chunk = '0;
    w_acc     = i_carry;
    for (int j = 0; j < STEP; j++) begin
      if (i_mask[j]) begin
        w_acc = w_acc ^ i_g_chunk[j];
      end
      o_b_chunk[j] = w_acc;
    end
    o_carry = w_acc;
  end

endmodule

// File: rtl/gray_codec_unit.sv
// Handshaked Gray-code engine: encode, iterative MSB-first decode and XOR-parity reduce.
module gray_codec_unit
  import gray_codec_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 4,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [2:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] outcu,
  output logic             op_err
);

  localparam int NCH  = calc_nch(WIDTH, STEP);
  localparam int CW   = calc_cnt_w(WIDTH, STEP);
  localparam int NTAB = 2 ** CW;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_opnd;
  logic [OUT_W-1:0] r_out;
  logic             r_err;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic             w_accept;
  logic             w_last;
  logic             w_slice_carry;
  logic [STEP-1:0]  w_g;
  logic [STEP-1:0]  w_mask;
  logic [STEP-1:0]  w_b;
  logic [STEP-1:0]  w_gk [NTAB];
  logic [STEP-1:0]  w_mk [NTAB];
  logic [WIDTH-1:0] w_dec;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign outcu     = r_out;
  assign op_err    = r_err;
  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_cnt == CW'(NCH - 1));

  // Static chunk/lane routing table; lanes that fall below bit 0 read as masked zeros.
  genvar gi, gj;
  generate
    for (gi = 0; gi < NTAB; gi++) begin : g_chunk
      for (gj = 0; gj < STEP; gj++) begin : g_lane
        localparam int IDX = WIDTH - 1 - gi * STEP - gj;
        if (IDX >= 0) begin : g_live
          assign w_gk[gi][gj] = r_opnd[IDX];
          assign w_mk[gi][gj] = 1'b1;
        end else begin : g_dead
          assign w_gk[gi][gj] = 1'b0;
          assign w_mk[gi][gj] = 1'b0;
        end
      end
    end
  endgenerate

  assign w_g    = w_gk[r_cnt];
  assign w_mask = w_mk[r_cnt];

  gray_dec_slice #(
    .STEP(STEP)
  ) u_slice (
    .i_carry   (r_carry),
    .i_g_chunk (w_g),
    .i_mask    (w_mask),
    .o_b_chunk (w_b),
    .o_carry   (w_slice_carry)
  );

  // Each result bit is owned by exactly one chunk; other chunks leave it unchanged.
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_wb
      localparam int POS  = WIDTH - 1 - gi;
      localparam int CH   = POS / STEP;
      localparam int LANE = POS % STEP;
      assign w_dec[gi] = (r_cnt == CW'(CH)) ? w_b[LANE] : r_out[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_next = (opcode == OP_DEC) ? BUSY : DONE;
      BUSY: if (w_last) w_state_next = DONE;
      DONE: if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opnd  <= '0;
      r_out   <= '0;
      r_err   <= 1'b0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_carry <= 1'b0;
            r_cnt   <= '0;
            case (opcode)
              OP_ENC: begin
                r_out <= OUT_W'(a ^ (a >> 1));
                r_err <= 1'b0;
              end
              OP_PAR: begin
                r_out <= OUT_W'(^a);
                r_err <= 1'b0;
              end
              OP_DEC: begin
                r_opnd <= a;
                r_out  <= '0;
                r_err  <= 1'b0;
              end
              default: begin
                r_out <= '0;
                r_err <= 1'b1;
              end
            endcase
          end
        end
        BUSY: begin
          r_out[WIDTH-1:0] <= w_dec;
          r_carry          <= w_slice_carry;
          r_cnt            <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
